// File: rtl/multibit_sync_stable.sv
// Synchronises an asynchronous multibit level bus into i_clock. A new value reaches
// o_data only after the synchronised bus has held that value for STABLE_CYCLES cycles.
module multibit_sync_stable #(
  parameter int              NB            = 8,
  parameter int              N_SYNC        = 2,
  parameter int              STABLE_CYCLES = 3,
  parameter int              NB_CNT        = 8,
  parameter logic [NB-1:0]   RESET_VALUE   = '0
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic [NB-1:0]     i_data,
  output logic [NB-1:0]     o_data,
  output logic              o_update,
  output logic              o_pending,
  output logic [NB_CNT-1:0] o_abort_count
);

  localparam int                 CNT_W     = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [NB_CNT-1:0]  ABORT_MAX = '1;

  if (N_SYNC < 2) begin : g_bad_n_sync
    $error("multibit_sync_stable: N_SYNC must be >= 2");
  end
  if (STABLE_CYCLES < 1) begin : g_bad_stable_cycles
    $error("multibit_sync_stable: STABLE_CYCLES must be >= 1");
  end

  logic [NB-1:0]    sync_q [N_SYNC];
  logic [NB-1:0]    sync_s;
  logic [NB-1:0]    cand;
  logic [CNT_W-1:0] cnt;
  logic             s_changed;
  logic             cand_pending;
  logic             commit;

  // Plain shift chain per bit: nothing combinational between stages.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      for (int i = 0; i < N_SYNC; i++) sync_q[i] <= RESET_VALUE;
    end else begin
      sync_q[0] <= i_data;
      for (int i = 1; i < N_SYNC; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_s = sync_q[N_SYNC-1];

  always_comb begin
    s_changed    = (sync_s != cand);
    cand_pending = (cand != o_data);
    commit       = !s_changed && (cnt == CNT_MAX) && cand_pending;
  end

  // o_update is a valid-only strobe (no ready): it is high for exactly the one cycle
  // in which o_data first shows a newly committed value; the consumer cannot stall it.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      cand          <= RESET_VALUE;
      cnt           <= '0;
      o_data        <= RESET_VALUE;
      o_update      <= 1'b0;
      o_abort_count <= '0;
    end else begin
      o_update <= commit;
      if (s_changed) begin
        // A moving bus always restarts qualification, even on the would-be commit edge.
        cand <= sync_s;
        cnt  <= CNT_ONE;
        if (cand_pending && (o_abort_count != ABORT_MAX))
          o_abort_count <= o_abort_count + 1'b1;
      end else if (commit) begin
        o_data <= cand;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign o_pending = cand_pending;

endmodule

// File: tb/tb_multibit_sync_stable.sv
// Bench for multibit_sync_stable: directed scenarios plus randomized skewed traffic,
// scored against a run-length model of the delayed input stream.
module tb_multibit_sync_stable;

  localparam int            NB        = 8;
  localparam int            N_SYNC    = 2;
  localparam int            SC        = 3;
  localparam int            NB_CNT    = 2;
  localparam logic [NB-1:0] RV        = '0;
  localparam int            ABORT_SAT = (1 << NB_CNT) - 1;

  logic              i_clock   = 1'b0;
  logic              i_reset_n = 1'b0;
  logic [NB-1:0]     i_data    = '0;
  logic [NB-1:0]     o_data;
  logic              o_update;
  logic              o_pending;
  logic [NB_CNT-1:0] o_abort_count;

  multibit_sync_stable #(
    .NB(NB), .N_SYNC(N_SYNC), .STABLE_CYCLES(SC), .NB_CNT(NB_CNT), .RESET_VALUE(RV)
  ) dut (
    .i_clock(i_clock), .i_reset_n(i_reset_n), .i_data(i_data), .o_data(o_data),
    .o_update(o_update), .o_pending(o_pending), .o_abort_count(o_abort_count)
  );

  // ---------------- clock / reset ----------------
  always #20 i_clock = ~i_clock;

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  int checks = 0;
  int errors = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  // ---------------- reference model ----------------
  // s is i_data seen N_SYNC edges later; a value commits once it has been seen on
  // SC earlier edges and again now while differing from the committed value.
  logic [NB-1:0] pipe[$];
  logic [NB-1:0] exp_q[$];
  logic [NB-1:0] m_s;
  logic [NB-1:0] run_val = RV;
  int            run_len = 0;
  logic [NB-1:0] m_out   = RV;
  int            m_abort = 0;
  bit            m_update = 1'b0;

  always @(posedge i_clock) begin
    if (!i_reset_n) begin
      pipe.delete();
      for (int i = 0; i < N_SYNC; i++) pipe.push_back(RV);
      run_val  = RV;
      run_len  = 0;
      m_out    = RV;
      m_abort  = 0;
      m_update = 1'b0;
      exp_q.delete();
    end else begin
      m_s = pipe.pop_front();
      pipe.push_back(i_data);
      m_update = 1'b0;
      if (m_s != run_val) begin
        if (run_val != m_out && m_abort < ABORT_SAT) m_abort++;
        run_val = m_s;
        run_len = 1;
      end else begin
        if (run_len >= SC && run_val != m_out) begin
          m_out    = run_val;
          m_update = 1'b1;
          exp_q.push_back(m_out);
        end
        run_len++;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [NB-1:0] sb_exp;

  always @(negedge i_clock) begin
    check("update", o_update, m_update);
    check("data", o_data, m_out);
    check("pending", o_pending, run_val != m_out);
    check("abort_count", o_abort_count, m_abort);
    if (o_update) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL commit_unexpected actual=%0h required=none", o_data);
      end else begin
        sb_exp = exp_q.pop_front();
        check("commit_value", o_data, sb_exp);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input logic [NB-1:0] v, input int n);
    @(negedge i_clock);
    i_reset_n = 1'b0;
    i_data    = v;
    repeat (n) @(negedge i_clock);
    i_reset_n = 1'b1;
  endtask

  // Observes 'budget' edges; the first one is labelled 'base'.
  task automatic watch_updates(input int budget, input int base, output int edge_idx, output int n_upd);
    edge_idx = -1;
    n_upd    = 0;
    for (int k = 0; k < budget; k++) begin
      @(posedge i_clock);
      #1;
      if (o_update) begin
        n_upd++;
        if (edge_idx < 0) edge_idx = base + k;
      end
    end
  endtask

  // Called at a negedge: every bit lands 1..15 time units later, before the next posedge.
  task automatic drive_skew(input logic [NB-1:0] v);
    int d[NB];
    for (int b = 0; b < NB; b++) d[b] = $urandom_range(1, 15);
    for (int t = 1; t <= 15; t++) begin
      #1;
      for (int b = 0; b < NB; b++) if (d[b] == t) i_data[b] = v[b];
    end
  endtask

  // ---------------- stimulus ----------------
  int            e;
  int            n;
  logic [NB-1:0] v;

  initial begin
    i_reset_n = 1'b0;
    i_data    = 8'hFF;
    repeat (3) @(negedge i_clock);
    check("reset_data", o_data, 8'h00);
    check("reset_update", o_update, 1'b0);
    check("reset_pending", o_pending, 1'b0);
    check("reset_abort", o_abort_count, 0);
    i_reset_n = 1'b1;
    watch_updates(10, 0, e, n);
    check("release_commit_edge", e, 5);
    check("release_pulses", n, 1);
    check("release_data", o_data, 8'hFF);

    // clean change
    do_reset(8'h00, 2);
    repeat (4) @(negedge i_clock);
    i_data = 8'hA5;
    watch_updates(10, 0, e, n);
    check("clean_commit_edge", e, 5);
    check("clean_pulses", n, 1);
    check("clean_data", o_data, 8'hA5);
    check("clean_abort", o_abort_count, 0);

    // skewed intermediate code for one cycle
    do_reset(8'h00, 2);
    repeat (4) @(negedge i_clock);
    i_data = 8'h0F;
    @(negedge i_clock);
    i_data = 8'hFF;
    watch_updates(10, 1, e, n);
    check("skew_commit_edge", e, 6);
    check("skew_pulses", n, 1);
    check("skew_data", o_data, 8'hFF);
    check("skew_abort", o_abort_count, 1);

    // glitch rejection
    do_reset(8'h00, 2);
    repeat (4) @(negedge i_clock);
    i_data = 8'h3C;
    repeat (2) @(negedge i_clock);
    i_data = 8'h00;
    watch_updates(8, 2, e, n);
    check("glitch_pulses", n, 0);
    check("glitch_data", o_data, 8'h00);
    check("glitch_abort", o_abort_count, 1);
    check("glitch_pending", o_pending, 1'b0);

    // s changes on the edge where the count has just reached SC
    do_reset(8'h00, 2);
    repeat (4) @(negedge i_clock);
    i_data = 8'h5A;
    repeat (SC) @(negedge i_clock);
    i_data = 8'hC3;
    watch_updates(12, SC, e, n);
    check("collision_commit_edge", e, 2 * SC + 2);
    check("collision_pulses", n, 1);
    check("collision_data", o_data, 8'hC3);
    check("collision_abort", o_abort_count, 1);

    // abort saturation, then reset while pending
    do_reset(8'h00, 2);
    repeat (4) @(negedge i_clock);
    for (int g = 0; g < 5; g++) begin
      i_data = 8'($urandom_range(1, 255));
      @(negedge i_clock);
      i_data = 8'h00;
      repeat (4) @(negedge i_clock);
    end
    repeat (3) @(negedge i_clock);
    check("sat_abort", o_abort_count, ABORT_SAT);
    check("sat_data", o_data, 8'h00);
    i_data = 8'h55;
    repeat (3) @(negedge i_clock);
    check("midreset_pending_before", o_pending, 1'b1);
    i_reset_n = 1'b0;
    @(posedge i_clock);
    #1;
    check("midreset_data", o_data, RV);
    check("midreset_abort", o_abort_count, 0);
    check("midreset_update", o_update, 1'b0);
    check("midreset_pending", o_pending, 1'b0);
    @(negedge i_clock);
    i_reset_n = 1'b1;

    // randomized skewed traffic, scored by the monitor
    for (int op = 0; op < 250; op++) begin
      @(negedge i_clock);
      if ($urandom_range(0, 39) == 0) begin
        i_reset_n = 1'b0;
        repeat ($urandom_range(1, 2)) @(negedge i_clock);
        i_reset_n = 1'b1;
      end
      case ($urandom_range(0, 3))
        0:       v = o_data;
        1:       v = 8'h00;
        default: v = 8'($urandom);
      endcase
      drive_skew(v);
      repeat ($urandom_range(0, 5)) @(negedge i_clock);
    end
    repeat (12) @(negedge i_clock);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
